// File: rtl/ltl_feeder_pkg.sv
// Shared types and constants for the LTL symbol feeder.
// Imported by the feeder top and its word FIFO.
package ltl_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } feeder_state_t;

   localparam int ARM_CYCLES = 2;

   function automatic int sym_per_word(input int word_w, input int sym_w);
      return word_w / sym_w;
   endfunction

endpackage

// File: rtl/ltl_word_fifo.sv
// Small synchronous word FIFO with async active-low reset.
// Stores {last, word}; a pop in the same cycle frees room for a push.
module ltl_word_fifo
   import ltl_feeder_pkg::*;
#(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ltl_symbol_feeder.sv
// Trace-word to automata symbol feeder: buffers words, serializes them
// LSB-first, drives monitor reset/run and captures the first report hit.
module ltl_symbol_feeder
   import ltl_feeder_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int SYM_W      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int N_REPORTS  = 4,
   parameter int IDX_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start_i,
   input  logic                 word_valid_i,
   input  logic [WORD_W-1:0]    word_i,
   input  logic                 word_last_i,
   output logic                 word_ready_o,
   output logic                 mon_reset_o,
   output logic                 mon_run_o,
   output logic [SYM_W-1:0]     mon_symbol_o,
   input  logic [N_REPORTS-1:0] report_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 hit_o,
   output logic [N_REPORTS-1:0] hit_vec_o,
   output logic [IDX_W-1:0]     hit_idx_o
);

   localparam int SPW = sym_per_word(WORD_W, SYM_W);
   localparam int CW  = (SPW > 1) ? $clog2(SPW) : 1;

   feeder_state_t state;
   feeder_state_t state_nxt;

   logic [1:0]        arm_cnt;
   logic [CW-1:0]     sym_cnt;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_d;
   logic              run_d;
   logic              last_acc;
   logic [SYM_W-1:0]  sym_q;
   logic [SYM_W-1:0]  cur_sym;
   logic [WORD_W-1:0] head_shift;
   logic              streaming;
   logic              accepting;
   logic              session_start;
   logic              word_end;
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [WORD_W:0]   fifo_dout;

   ltl_word_fifo #(
      .W     (WORD_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (session_start),
      .push    (fifo_push),
      .din     ({word_last_i, word_i}),
      .pop     (word_end),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign session_start = (state == ST_IDLE) && start_i;
   assign word_ready_o  = accepting && !fifo_full && !last_acc;
   assign fifo_push     = word_valid_i && word_ready_o;
   assign mon_run_o     = streaming && !fifo_empty;
   assign word_end      = mon_run_o && (sym_cnt == CW'(SPW - 1));
   assign head_shift    = fifo_dout[WORD_W-1:0] >> (sym_cnt * SYM_W);
   assign cur_sym       = head_shift[SYM_W-1:0];
   assign mon_symbol_o  = mon_run_o ? cur_sym : sym_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (start_i) state_nxt = ST_ARM;
         ST_ARM:    if (arm_cnt == 2'(ARM_CYCLES - 1)) state_nxt = ST_STREAM;
         ST_STREAM: if (word_end && fifo_dout[WORD_W]) state_nxt = ST_DRAIN;
         ST_DRAIN:  state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // DRAIN keeps the monitor out of reset so the last symbol's report lands.
   always_comb begin
      mon_reset_o = 1'b1;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      streaming   = 1'b0;
      accepting   = 1'b0;
      unique case (state)
         ST_IDLE:   mon_reset_o = 1'b1;
         ST_ARM: begin
            busy_o    = 1'b1;
            accepting = 1'b1;
         end
         ST_STREAM: begin
            mon_reset_o = 1'b0;
            busy_o      = 1'b1;
            streaming   = 1'b1;
            accepting   = 1'b1;
         end
         ST_DRAIN: begin
            mon_reset_o = 1'b0;
            busy_o      = 1'b1;
         end
         ST_DONE:   done_o = 1'b1;
         default:   mon_reset_o = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arm_cnt   <= '0;
         sym_cnt   <= '0;
         idx       <= '0;
         idx_d     <= '0;
         run_d     <= 1'b0;
         last_acc  <= 1'b0;
         sym_q     <= '0;
         hit_o     <= 1'b0;
         hit_vec_o <= '0;
         hit_idx_o <= '0;
      end else begin
         run_d <= mon_run_o;
         idx_d <= idx;
         if (session_start) begin
            arm_cnt   <= '0;
            sym_cnt   <= '0;
            idx       <= '0;
            last_acc  <= 1'b0;
            hit_o     <= 1'b0;
            hit_vec_o <= '0;
            hit_idx_o <= '0;
         end else begin
            if (state == ST_ARM) arm_cnt <= arm_cnt + 1'b1;
            if (fifo_push && word_last_i) last_acc <= 1'b1;
            if (mon_run_o) begin
               sym_q   <= cur_sym;
               sym_cnt <= word_end ? '0 : sym_cnt + 1'b1;
               if (idx != '1) idx <= idx + 1'b1;
            end
            // report_i reflects the symbol presented one cycle earlier
            if (run_d && !hit_o && (|report_i)) begin
               hit_o     <= 1'b1;
               hit_vec_o <= report_i;
               hit_idx_o <= idx_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
// Randomized scoreboard bench for ltl_symbol_feeder (IDX_W=4 so the
// index saturation path is reached by ordinary sessions).
module tb_ltl_symbol_feeder;

   localparam int IDX_MAX = 15;

   typedef struct {
      logic       hit;
      logic [3:0] vec;
      logic [3:0] idx;
   } sess_t;

   logic        clk;
   logic        reset_n;
   logic        start_i;
   logic        word_valid_i;
   logic [31:0] word_i;
   logic        word_last_i;
   logic        word_ready_o;
   logic        mon_reset_o;
   logic        mon_run_o;
   logic [7:0]  mon_symbol_o;
   logic [3:0]  report_i;
   logic        busy_o;
   logic        done_o;
   logic        hit_o;
   logic [3:0]  hit_vec_o;
   logic [3:0]  hit_idx_o;

   ltl_symbol_feeder #(
      .WORD_W     (32),
      .SYM_W      (8),
      .FIFO_DEPTH (4),
      .N_REPORTS  (4),
      .IDX_W      (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_i      (start_i),
      .word_valid_i (word_valid_i),
      .word_i       (word_i),
      .word_last_i  (word_last_i),
      .word_ready_o (word_ready_o),
      .mon_reset_o  (mon_reset_o),
      .mon_run_o    (mon_run_o),
      .mon_symbol_o (mon_symbol_o),
      .report_i     (report_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .hit_o        (hit_o),
      .hit_vec_o    (hit_vec_o),
      .hit_idx_o    (hit_idx_o)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          ord = 0;
   int          busy_cyc = 0;
   int          stalls = 0;
   bit          last_acc = 0;
   bit          prev_done = 0;
   logic [7:0]  last_sym = 8'h00;
   logic [3:0]  next_rep = 4'h0;
   logic [31:0] wq[$];
   logic [7:0]  exp_sym[$];
   logic [3:0]  plan[int];
   sess_t       exp_sess[$];
   sess_t       e_mon;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: symbols are bytes LSB first; first nonzero planned report wins.
   task automatic prepare();
      sess_t e;
      int nsym;
      nsym = wq.size() * 4;
      e.hit = 1'b0;
      e.vec = 4'h0;
      e.idx = 4'h0;
      foreach (wq[i])
         for (int b = 0; b < 4; b++)
            exp_sym.push_back(wq[i][8*b +: 8]);
      for (int k = 0; k < nsym; k++)
         if (!e.hit && plan.exists(k) && plan[k] != 4'h0) begin
            e.hit = 1'b1;
            e.vec = plan[k];
            e.idx = (k > IDX_MAX) ? 4'(IDX_MAX) : 4'(k);
         end
      exp_sess.push_back(e);
      ord = 0;
   endtask

   task automatic start_session();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send_words(input int gap, input bit rnd, input bit mid_start,
                             input bit hold);
      bit acc;
      int g;
      stalls = 0;
      for (int i = 0; i < wq.size(); i++) begin
         g = rnd ? int'($urandom_range(0, 3)) : gap;
         if (g > 0) begin
            word_valid_i = 1'b0;
            repeat (g) tick();
         end
         word_i       = wq[i];
         word_last_i  = (i == wq.size() - 1);
         word_valid_i = 1'b1;
         if (mid_start && i == 1) start_i = 1'b1;
         acc = 1'b0;
         for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = word_ready_o;
            if (!acc) stalls++;
            tick();
            start_i = 1'b0;
         end
         chk("word_accept", 32'(acc), 1);
      end
      last_acc     = 1'b1;
      word_valid_i = hold;
      word_i       = $urandom;
      word_last_i  = 1'($urandom);
   endtask

   task automatic finish_session();
      bit got;
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(negedge clk);
         got = done_o;
      end
      chk("done_seen", 32'(got), 1);
      tick();
      word_valid_i = 1'b0;
      word_last_i  = 1'b0;
      last_acc     = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic session(input int gap, input bit rnd, input bit mid_start,
                          input bit hold);
      prepare();
      start_session();
      send_words(gap, rnd, mid_start, hold);
      finish_session();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mon_reset"}, 32'(mon_reset_o), 1);
      chk({tag, "_ready"}, 32'(word_ready_o), 0);
      chk({tag, "_run"}, 32'(mon_run_o), 0);
      chk({tag, "_symbol"}, 32'(mon_symbol_o), 0);
      chk({tag, "_busy"}, 32'(busy_o), 0);
      chk({tag, "_done"}, 32'(done_o), 0);
      chk({tag, "_hit"}, 32'(hit_o), 0);
      chk({tag, "_hit_vec"}, 32'(hit_vec_o), 0);
      chk({tag, "_hit_idx"}, 32'(hit_idx_o), 0);
   endtask

   // Report lines answer one cycle after a symbol; otherwise drive noise.
   initial begin
      report_i = 4'h0;
      forever begin
         @(posedge clk);
         #1;
         report_i = next_rep;
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (mon_run_o) begin
            chk("sym_avail", 32'(exp_sym.size() > 0), 1);
            if (exp_sym.size() > 0)
               chk("symbol", 32'(mon_symbol_o), 32'(exp_sym.pop_front()));
            last_sym = mon_symbol_o;
            next_rep = plan.exists(ord) ? plan[ord] : 4'h0;
            ord++;
         end else begin
            if (busy_o) chk("sym_hold", 32'(mon_symbol_o), 32'(last_sym));
            next_rep = 4'($urandom);
         end
         if (busy_o) begin
            busy_cyc++;
            if (busy_cyc <= 2) begin
               chk("arm_mon_reset", 32'(mon_reset_o), 1);
               chk("arm_run", 32'(mon_run_o), 0);
            end else begin
               chk("stream_mon_reset", 32'(mon_reset_o), 0);
            end
         end else begin
            busy_cyc = 0;
            chk("idle_ready", 32'(word_ready_o), 0);
            chk("idle_run", 32'(mon_run_o), 0);
            if (!done_o) chk("idle_mon_reset", 32'(mon_reset_o), 1);
         end
         if (last_acc) chk("post_last_ready", 32'(word_ready_o), 0);
         if (done_o) begin
            chk("done_pulse", 32'(prev_done), 0);
            chk("done_busy", 32'(busy_o), 0);
            chk("sess_pending", 32'(exp_sess.size() > 0), 1);
            if (exp_sess.size() > 0) begin
               e_mon = exp_sess.pop_front();
               chk("hit", 32'(hit_o), 32'(e_mon.hit));
               chk("hit_vec", 32'(hit_vec_o), 32'(e_mon.vec));
               chk("hit_idx", 32'(hit_idx_o), 32'(e_mon.idx));
               chk("syms_left", 32'(exp_sym.size()), 0);
            end
         end
         prev_done = done_o;
      end
   end

   initial begin : stimulus
      reset_n      = 1'b0;
      start_i      = 1'b0;
      word_valid_i = 1'b0;
      word_i       = '0;
      word_last_i  = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("por");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();

      // basic single word
      wq.delete(); plan.delete();
      wq.push_back(32'h00C08040);
      session(0, 0, 0, 0);

      // first hit at index 5, later report at 6 ignored
      wq.delete(); plan.delete();
      wq.push_back($urandom); wq.push_back($urandom);
      plan[5] = 4'b0100;
      plan[6] = 4'b0011;
      session(0, 0, 0, 0);

      // 3-cycle valid gaps force underflow
      wq.delete(); plan.delete();
      repeat (3) wq.push_back($urandom);
      plan[11] = 4'b0001;
      session(3, 0, 0, 0);

      // 6 back-to-back words must stall on a full buffer
      wq.delete(); plan.delete();
      repeat (6) wq.push_back($urandom);
      session(0, 0, 0, 0);
      chk("backpressure", 32'(stalls > 0), 1);

      // valid held after last, start pulsed mid-session
      wq.delete(); plan.delete();
      repeat (3) wq.push_back($urandom);
      plan[0] = 4'b1010;
      session(0, 0, 1, 1);

      // async reset while symbol 2 is on the bus
      wq.delete(); plan.delete();
      repeat (3) wq.push_back($urandom);
      prepare();
      start_session();
      send_words(0, 0, 0, 0);
      for (int c = 0; c < 50 && ord < 3; c++) begin
         @(negedge clk);
         #1;
      end
      chk("reset_point", 32'(ord), 3);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("mid");
      exp_sym.delete();
      if (exp_sess.size() > 0) void'(exp_sess.pop_back());
      plan.delete();
      last_acc     = 1'b0;
      last_sym     = 8'h00;
      word_valid_i = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // clean session after reset
      wq.delete(); plan.delete();
      repeat (2) wq.push_back($urandom);
      plan[0] = 4'b0110;
      session(0, 0, 0, 0);

      // index saturation: hit on symbol 18 reports 15
      wq.delete(); plan.delete();
      repeat (5) wq.push_back($urandom);
      plan[18] = 4'b1000;
      session(0, 0, 0, 0);

      for (int s = 0; s < 20; s++) begin
         int nw;
         wq.delete(); plan.delete();
         nw = int'($urandom_range(1, 6));
         repeat (nw) wq.push_back($urandom);
         for (int k = 0; k < nw * 4; k++)
            if ($urandom_range(0, 9) == 0) plan[k] = 4'($urandom);
         session(0, 1, nw > 1 && $urandom_range(0, 1) == 1,
                 1'($urandom));
      end

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ltl_symbol_feeder.md
Name: ltl_symbol_feeder

Overview:
- Transmit-side front end for the automata monitor clusters: accepts 32-bit trace words from the core trace port and buffers them.
- Serializes each word into 8-bit symbols and drives the monitor's run/reset/symbol interface, including the reset pulse that arms start-of-data.
- Samples the monitor report lines one cycle after each symbol and records the first violating symbol index per trace session.
- One instance per monitor cluster; sits between the trace arbiter and the cluster's automata.

Parameters:
WORD_W, 32, trace word width; must be a multiple of SYM_W
SYM_W, 8, symbol width fed to the automata
FIFO_DEPTH, 4, word buffer entries (power of two, >= 2)
N_REPORTS, 4, number of report lines from the cluster
IDX_W, 16, symbol index counter width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start_i  in  1  begin new trace session (pulse)
word_valid_i  in  1  trace word valid
word_i  in  WORD_W  trace word
word_last_i  in  1  final word of session
word_ready_o  out  1  word accepted when valid & ready
mon_reset_o  out  1  monitor reset (active high)
mon_run_o  out  1  symbol on mon_symbol_o is consumed this cycle
mon_symbol_o  out  SYM_W  symbol to automata
report_i  in  N_REPORTS  OR'd report outputs of the cluster
busy_o  out  1  session in progress
done_o  out  1  one-cycle pulse at session end
hit_o  out  1  sticky: a report fired this session
hit_vec_o  out  N_REPORTS  report_i value at first hit
hit_idx_o  out  IDX_W  index of the symbol that caused the first hit

Behaviour:
- Reset (async assert, sync deassert use): state IDLE, FIFO empty, all outputs 0 except mon_reset_o=1 (monitor held in reset while idle).
- FSM IDLE -> ARM -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: mon_reset_o=1, word_ready_o=0. start_i=1 -> ARM; clears hit_o/hit_vec_o/hit_idx_o, symbol index, FIFO.
- ARM: 2 cycles. mon_reset_o=1 so the monitor's posedge and negedge start registers both latch. word_ready_o follows FIFO not-full. Then STREAM.
- STREAM: mon_reset_o=0.
  - Head word is emitted as WORD_W/SYM_W symbols, least-significant byte first, one per cycle while mon_run_o=1.
  - FIFO empty -> mon_run_o=0, mon_symbol_o holds its last value, index does not advance.
  - After the last symbol of the word flagged last -> DRAIN.
- Input handshake: word_ready_o = FIFO not full and last not yet accepted. Words offered in IDLE/DRAIN/DONE are not accepted. Once word_last_i is accepted, ready stays 0 until the next session. Simultaneous push and pop with the FIFO full is allowed only when the pop frees the entry; ready itself is computed from the registered full flag.
- Report sampling: the automaton STE output is registered, so report_i for symbol k is sampled on the cycle after mon_run_o=1 presented k. A delayed run flag plus delayed index qualify the sample. On the first nonzero qualified sample: hit_o=1, hit_vec_o=report_i, hit_idx_o=k. Later hits are ignored. Unqualified report_i is ignored.
- DRAIN: exactly 1 cycle, so the last symbol's report is sampled; then DONE.
- DONE: done_o=1 for 1 cycle, busy_o drops, -> IDLE, mon_reset_o=1 again. Hit outputs stay valid until the next start_i.
- busy_o=1 in ARM, STREAM, DRAIN.
- start_i while busy is ignored.
- Symbol index: 0-based, increments per consumed symbol, saturates at 2^IDX_W-1.
- reset_n asserted mid-session: immediate return to reset values; partial session discarded, no done_o.

Decomposition:
- Shared package ltl_feeder_pkg: FSM state enum, SYM_PER_WORD = WORD_W/SYM_W, ARM_CYCLES = 2.
- One sub-module ltl_word_fifo: parameterized synchronous FIFO with async active-low reset, push/pop/full/empty, storing {last, word}.
- Serializer, FSM and report capture live in the top module.

Test Plan:
- Basic: start_i, one word 0x00C08040 with last=1, report_i=0 -> mon_reset_o high 2 cycles after start; symbols 0x40,0x80,0xC0,0x00 on 4 consecutive run cycles; done_o 1 cycle after DRAIN; hit_o=0.
- Hit capture: 2 words, report_i=4'b0100 only on the cycle after symbol index 5 -> hit_o=1, hit_vec_o=4'b0100, hit_idx_o=5. A further report at index 6 leaves hit_idx_o=5.
- Backpressure/underflow: valid gaps of 3 cycles between words -> mon_run_o low during gaps, mon_symbol_o held, indices contiguous 0..11 for 3 words. Back-to-back 6 words with depth 4 -> word_ready_o drops when full, no word lost or duplicated.
- Post-last blocking: word_valid_i held after last accepted -> word_ready_o=0 until the next start_i; start_i pulsed mid-STREAM is ignored.
- Async reset mid-STREAM: reset_n low at symbol 2 -> outputs go to reset values immediately, mon_reset_o=1, no done_o. A new session then runs cleanly from index 0.
- Saturation: IDX_W=4, 5 words (20 symbols), report fired after symbol 18 -> hit_idx_o=15.
